// File: rtl/ex_stage_ctrl.sv
// ID/EX boundary: registers ID control bundles, decodes the ALU op, stalls IF/ID on load-use.
// Optional operand forwarding is enabled by defining EX_FORWARDING_EN.
module ex_stage_ctrl #(
  parameter int unsigned STALL_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [4:0]  i_rdReg1,
  input  logic [4:0]  i_rdReg2,
  input  logic [13:0] i_ctrlEX,
  input  logic [3:0]  i_ctrlMEM,
  input  logic [6:0]  i_ctrlWB,
  input  logic        i_flush,
  input  logic        i_exmemRegWr,
  input  logic [4:0]  i_exmemRd,
  input  logic        i_memwbRegWr,
  input  logic [4:0]  i_memwbRd,
  output logic        o_stall,
  output logic        o_valid,
  output logic [3:0]  o_aluOp,
  output logic [1:0]  o_aluSrc,
  output logic [2:0]  o_func3,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [3:0]  o_ctrlMEM,
  output logic [6:0]  o_ctrlWB,
  output logic [1:0]  o_fwdA,
  output logic [1:0]  o_fwdB
);

  typedef enum logic {S_RUN, S_BUBBLE} state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
    ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
    ALU_OR   = 4'd8, ALU_AND = 4'd9
  } alu_t;

  localparam logic [2:0] LP_CNT_INIT = 3'(STALL_CYCLES - 1);

  state_t      r_state, w_state_nxt;
  logic [2:0]  r_cnt, w_cnt_nxt;
  logic        w_hit, w_load;
  logic        r_valid;
  logic [13:0] r_ctrlEX;
  logic [4:0]  r_rs1, r_rs2;
  logic [3:0]  r_ctrlMEM;
  logic [6:0]  r_ctrlWB;
  alu_t        w_aluOp;

  assign w_hit = r_valid & r_ctrlMEM[1] & (r_ctrlWB[4:0] != 5'd0) & i_valid &
                 ((r_ctrlWB[4:0] == i_rdReg1) | (r_ctrlWB[4:0] == i_rdReg2));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Flush overrides both a new hazard and an in-progress bubble run.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_stall     = 1'b0;
    w_load      = 1'b0;
    if (i_flush) begin
      w_state_nxt = S_RUN;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_hit) begin
            o_stall     = 1'b1;
            w_cnt_nxt   = LP_CNT_INIT;
            w_state_nxt = (STALL_CYCLES == 1) ? S_RUN : S_BUBBLE;
          end else begin
            w_load = i_valid;
          end
        end
        S_BUBBLE: begin
          o_stall = 1'b1;
          if (r_cnt <= 3'd1) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_RUN;
          end else begin
            w_cnt_nxt = r_cnt - 3'd1;
          end
        end
        default: begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid   <= 1'b0;
      r_ctrlEX  <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_ctrlMEM <= '0;
      r_ctrlWB  <= '0;
    end else if (w_load) begin
      r_valid   <= 1'b1;
      r_ctrlEX  <= i_ctrlEX;
      r_rs1     <= i_rdReg1;
      r_rs2     <= i_rdReg2;
      r_ctrlMEM <= i_ctrlMEM;
      r_ctrlWB  <= i_ctrlWB;
    end else begin
      r_valid   <= 1'b0;
      r_ctrlEX  <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_ctrlMEM <= '0;
      r_ctrlWB  <= '0;
    end
  end

  always_comb begin
    w_aluOp = ALU_ADD;
    case (r_ctrlEX[13:12])
      2'b01: w_aluOp = ALU_SUB;
      2'b10: begin
        case (r_ctrlEX[9:7])
          3'b000:  w_aluOp = r_ctrlEX[5] ? ALU_SUB : ALU_ADD;
          3'b001:  w_aluOp = ALU_SLL;
          3'b010:  w_aluOp = ALU_SLT;
          3'b011:  w_aluOp = ALU_SLTU;
          3'b100:  w_aluOp = ALU_XOR;
          3'b101:  w_aluOp = r_ctrlEX[5] ? ALU_SRA : ALU_SRL;
          3'b110:  w_aluOp = ALU_OR;
          default: w_aluOp = ALU_AND;
        endcase
      end
      default: w_aluOp = ALU_ADD;
    endcase
  end

  assign o_valid   = r_valid;
  assign o_aluOp   = w_aluOp;
  assign o_aluSrc  = r_ctrlEX[11:10];
  assign o_func3   = r_ctrlEX[9:7];
  assign o_rs1     = r_rs1;
  assign o_rs2     = r_rs2;
  assign o_ctrlMEM = r_ctrlMEM;
  assign o_ctrlWB  = r_ctrlWB;

`ifdef EX_FORWARDING_EN
  always_comb begin
    o_fwdA = 2'b00;
    o_fwdB = 2'b00;
    if (i_exmemRegWr && (i_exmemRd != 5'd0) && (i_exmemRd == r_rs1))      o_fwdA = 2'b10;
    else if (i_memwbRegWr && (i_memwbRd != 5'd0) && (i_memwbRd == r_rs1)) o_fwdA = 2'b01;
    if (i_exmemRegWr && (i_exmemRd != 5'd0) && (i_exmemRd == r_rs2))      o_fwdB = 2'b10;
    else if (i_memwbRegWr && (i_memwbRd != 5'd0) && (i_memwbRd == r_rs2)) o_fwdB = 2'b01;
  end
`else
  logic w_unused_fwd;
  assign w_unused_fwd = ^{i_exmemRegWr, i_exmemRd, i_memwbRegWr, i_memwbRd};
  assign o_fwdA = 2'b00;
  assign o_fwdB = 2'b00;
`endif

endmodule
